// File: rtl/exec_sequencer_pkg.sv
// Shared types and widths for the MAC pass sequencer.
package exec_sequencer_pkg;

  localparam int COL_W   = 4;
  localparam int ADDR_W  = 5;
  localparam int RBUF_AW = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN,
    SWAP
  } state_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// Command, beat-handshake and MAC/rbuf control bundle of the pass sequencer.
interface exec_sequencer_if
  import exec_sequencer_pkg::*;
  ();

  logic               start_valid;
  logic               start_ready;
  logic [ADDR_W-1:0]  cfg_w_rows;
  logic [ADDR_W-1:0]  cfg_a_rows;
  logic [RBUF_AW-1:0] cfg_rbuf_base;
  logic               w_valid;
  logic               w_ready;
  logic               a_valid;
  logic               a_ready;
  logic               mac_w_en_n;
  logic [COL_W-1:0]   mac_w_col;
  logic [ADDR_W-1:0]  mac_w_addr;
  logic               mac_r_en_n;
  logic [ADDR_W-1:0]  mac_r_addr;
  logic [RBUF_AW-1:0] rbuf_w_addr;
  logic               swap_n;
  logic               busy;
  logic               done;

  modport master (
    output start_valid, cfg_w_rows, cfg_a_rows, cfg_rbuf_base, w_valid, a_valid,
    input  start_ready, w_ready, a_ready, mac_w_en_n, mac_w_col, mac_w_addr,
    input  mac_r_en_n, mac_r_addr, rbuf_w_addr, swap_n, busy, done
  );

  modport slave (
    input  start_valid, cfg_w_rows, cfg_a_rows, cfg_rbuf_base, w_valid, a_valid,
    output start_ready, w_ready, a_ready, mac_w_en_n, mac_w_col, mac_w_addr,
    output mac_r_en_n, mac_r_addr, rbuf_w_addr, swap_n, busy, done
  );

endinterface

// File: rtl/exec_sequencer_nested_counter.sv
// Inner/outer wrap counter: inner runs 0..inner_max, outer advances on each inner wrap.
module nested_counter #(
  parameter int INNER_W = 5,
  parameter int OUTER_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               step,
  input  logic [INNER_W-1:0] inner_max,
  input  logic [OUTER_W-1:0] outer_max,
  output logic [INNER_W-1:0] inner,
  output logic [OUTER_W-1:0] outer
);

  logic [INNER_W-1:0] inner_reg, inner_next;
  logic [OUTER_W-1:0] outer_reg, outer_next;

  always_comb begin
    inner_next = inner_reg;
    outer_next = outer_reg;
    if (clear) begin
      inner_next = '0;
      outer_next = '0;
    end else if (step) begin
      if (inner_reg == inner_max) begin
        inner_next = '0;
        outer_next = (outer_reg == outer_max) ? '0 : outer_reg + OUTER_W'(1);
      end else begin
        inner_next = inner_reg + INNER_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inner_reg <= '0;
      outer_reg <= '0;
    end else begin
      inner_reg <= inner_next;
      outer_reg <= outer_next;
    end
  end

  assign inner = inner_reg;
  assign outer = outer_reg;

endmodule

// File: rtl/exec_sequencer.sv
// Pass sequencer: loads N_COLS weight columns, streams activation reads into rbuf,
// drains the MAC pipeline and strobes a buffer swap.
module exec_sequencer
  import exec_sequencer_pkg::*;
#(
  parameter int MAC_LAT = 2,
  parameter int N_COLS  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  exec_sequencer_if.slave  bus
);

  localparam int               DRAIN_W  = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N_COLS - 1);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  w_rows_reg;
  logic [ADDR_W-1:0]  a_rows_reg;
  logic [RBUF_AW-1:0] base_reg;
  logic [DRAIN_W-1:0] drain_reg;

  logic               start_fire, w_fire, a_fire;
  logic               ld_last, cmp_last;
  logic [ADDR_W-1:0]  addr, idx;
  logic [COL_W-1:0]   col;
  logic               cmp_pass;

  assign start_fire = (state_reg == IDLE) && bus.start_valid;
  assign w_fire     = (state_reg == LOAD) && bus.w_valid;
  assign a_fire     = (state_reg == COMPUTE) && bus.a_valid;

  nested_counter #(.INNER_W(ADDR_W), .OUTER_W(COL_W)) u_load_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (start_fire),
    .step      (w_fire),
    .inner_max (w_rows_reg),
    .outer_max (LAST_COL),
    .inner     (addr),
    .outer     (col)
  );

  // COMPUTE is a single outer pass, so the outer counter only ever holds 0.
  nested_counter #(.INNER_W(ADDR_W), .OUTER_W(1)) u_cmp_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (start_fire),
    .step      (a_fire),
    .inner_max (a_rows_reg),
    .outer_max (1'b0),
    .inner     (idx),
    .outer     (cmp_pass)
  );

  assign ld_last  = w_fire && (addr == w_rows_reg) && (col == LAST_COL);
  assign cmp_last = a_fire && (idx == a_rows_reg) && (cmp_pass == 1'b0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_rows_reg <= '0;
      a_rows_reg <= '0;
      base_reg   <= '0;
    end else if (start_fire) begin
      w_rows_reg <= bus.cfg_w_rows;
      a_rows_reg <= bus.cfg_a_rows;
      base_reg   <= bus.cfg_rbuf_base;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      drain_reg <= '0;
    end else if (cmp_last) begin
      drain_reg <= DRAIN_W'(MAC_LAT);
    end else if ((state_reg == DRAIN) && (drain_reg != '0)) begin
      drain_reg <= drain_reg - DRAIN_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start_valid) state_next = LOAD;
      LOAD:    if (ld_last) state_next = COMPUTE;
      COMPUTE: if (cmp_last) state_next = (MAC_LAT == 0) ? SWAP : DRAIN;
      // Last drain cycle is the one where the counter reads 1.
      DRAIN:   if (drain_reg <= DRAIN_W'(1)) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state_reg == IDLE);
    bus.w_ready     = (state_reg == LOAD);
    bus.a_ready     = (state_reg == COMPUTE);
    bus.mac_w_en_n  = ~w_fire;
    bus.mac_w_col   = col;
    bus.mac_w_addr  = addr;
    bus.mac_r_en_n  = ~a_fire;
    bus.mac_r_addr  = idx;
    bus.rbuf_w_addr = base_reg + RBUF_AW'(idx);
    bus.swap_n      = (state_reg != SWAP);
    bus.done        = (state_reg == SWAP);
    bus.busy        = (state_reg != IDLE);
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: load/compute sequencing, rbuf wrap, stalls,
// start masking, reset abandonment and the long weight load.
module tb_exec_sequencer;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  exec_sequencer_if bus ();

  exec_sequencer #(.MAC_LAT(2), .N_COLS(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Drives a start command in IDLE; returns one cycle after the fire edge (pass cycle 1).
  task automatic start_pass(input logic [4:0] w_rows, input logic [4:0] a_rows,
                            input logic [7:0] base);
    bus.cfg_w_rows    = w_rows;
    bus.cfg_a_rows    = a_rows;
    bus.cfg_rbuf_base = base;
    bus.start_valid   = 1'b1;
    cycle();
    bus.start_valid   = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    reset_n = 1'b0;
    bus.start_valid = 1'b0; bus.w_valid = 1'b0; bus.a_valid = 1'b0;
    bus.cfg_w_rows = '0; bus.cfg_a_rows = '0; bus.cfg_rbuf_base = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    got = {bus.start_ready, bus.w_ready, bus.a_ready, bus.mac_w_en_n,
           bus.mac_r_en_n, bus.swap_n, bus.done, bus.busy};
    vectors++;
    if (got !== 8'b1001_1100) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b want %b", got, 8'b1001_1100);
    end
    cycle();
    reset_n = 1'b1;
    cycle();
    $display("txn reset: outputs {srdy,wrdy,ardy,wen_n,ren_n,swap_n,done,busy}=%b", got);
  endtask

  task automatic test_basic();
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b1;
    start_pass(5'd0, 5'd3, 8'h10);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      vectors++;
      if (c <= 16) begin
        if ({bus.mac_w_en_n, bus.mac_w_col, bus.mac_w_addr, bus.w_ready, bus.a_ready, bus.mac_r_en_n}
            !== {1'b0, 4'(c - 1), 5'd0, 1'b1, 1'b0, 1'b1}) begin
          miscompares++;
          $display("FAIL basic_load c=%0d: got en_n=%b col=%0d addr=%0d wrdy=%b ardy=%b ren_n=%b want 0/%0d/0/1/0/1",
                   c, bus.mac_w_en_n, bus.mac_w_col, bus.mac_w_addr, bus.w_ready, bus.a_ready,
                   bus.mac_r_en_n, c - 1);
        end
      end else if (c <= 20) begin
        if ({bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr, bus.mac_w_en_n, bus.w_ready}
            !== {1'b0, 5'(c - 17), 8'(16 + c - 17), 1'b1, 1'b0}) begin
          miscompares++;
          $display("FAIL basic_compute c=%0d: got ren_n=%b raddr=%0d rbuf=%h wen_n=%b wrdy=%b want 0/%0d/%h/1/0",
                   c, bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr, bus.mac_w_en_n, bus.w_ready,
                   c - 17, 8'(16 + c - 17));
        end
      end else if (c <= 22) begin
        if ({bus.busy, bus.w_ready, bus.a_ready, bus.swap_n, bus.done} !== 5'b10010) begin
          miscompares++;
          $display("FAIL basic_drain c=%0d: got {busy,wrdy,ardy,swap_n,done}=%b want 10010", c,
                   {bus.busy, bus.w_ready, bus.a_ready, bus.swap_n, bus.done});
        end
      end else if (c == 23) begin
        if ({bus.swap_n, bus.done, bus.busy} !== 3'b011) begin
          miscompares++;
          $display("FAIL basic_swap c=%0d: got {swap_n,done,busy}=%b want 011", c,
                   {bus.swap_n, bus.done, bus.busy});
        end
      end else begin
        if ({bus.busy, bus.done, bus.start_ready} !== 3'b001) begin
          miscompares++;
          $display("FAIL basic_idle c=%0d: got {busy,done,srdy}=%b want 001", c,
                   {bus.busy, bus.done, bus.start_ready});
        end
      end
      cycle();
    end
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    $display("txn basic: w_rows=0 a_rows=3 base=10, swap expected at pass cycle 23 (fire cycle = 0)");
  endtask

  task automatic test_wrap();
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b1;
    start_pass(5'd0, 5'd3, 8'hFE);
    for (int c = 1; c <= 24; c++) begin
      @(negedge clock);
      if (c >= 17 && c <= 20) begin
        vectors++;
        if ({bus.mac_r_en_n, bus.rbuf_w_addr} !== {1'b0, 8'(254 + c - 17)}) begin
          miscompares++;
          $display("FAIL wrap_rbuf c=%0d: got ren_n=%b rbuf=%h want 0/%h", c, bus.mac_r_en_n,
                   bus.rbuf_w_addr, 8'(254 + c - 17));
        end
      end else if (c == 24) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL wrap_idle: got busy=%b want 0", bus.busy);
        end
      end
      cycle();
    end
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    $display("txn wrap: base=FE rbuf sequence FE FF 00 01");
  endtask

  task automatic test_a_toggle();
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b1;
    start_pass(5'd0, 5'd1, 8'h40);
    for (int c = 1; c <= 23; c++) begin
      if (c >= 17) bus.a_valid = (c == 17 || c == 19);
      @(negedge clock);
      vectors++;
      if (c <= 16) begin
        if ({bus.a_ready, bus.mac_r_en_n} !== 2'b01) begin
          miscompares++;
          $display("FAIL toggle_wrong_phase c=%0d: got {ardy,ren_n}=%b want 01", c,
                   {bus.a_ready, bus.mac_r_en_n});
        end
      end else if (c == 17 || c == 19) begin
        if ({bus.a_ready, bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr}
            !== {1'b1, 1'b0, 5'((c - 17) / 2), 8'(64 + (c - 17) / 2)}) begin
          miscompares++;
          $display("FAIL toggle_fire c=%0d: got ardy=%b ren_n=%b raddr=%0d rbuf=%h want 1/0/%0d/%h",
                   c, bus.a_ready, bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr,
                   (c - 17) / 2, 8'(64 + (c - 17) / 2));
        end
      end else if (c == 18) begin
        if ({bus.a_ready, bus.mac_r_en_n, bus.mac_r_addr} !== {1'b1, 1'b1, 5'd1}) begin
          miscompares++;
          $display("FAIL toggle_stall c=%0d: got ardy=%b ren_n=%b raddr=%0d want 1/1/1", c,
                   bus.a_ready, bus.mac_r_en_n, bus.mac_r_addr);
        end
      end else if (c <= 21) begin
        if ({bus.a_ready, bus.mac_r_en_n, bus.swap_n, bus.busy} !== 4'b0111) begin
          miscompares++;
          $display("FAIL toggle_drain c=%0d: got {ardy,ren_n,swap_n,busy}=%b want 0111", c,
                   {bus.a_ready, bus.mac_r_en_n, bus.swap_n, bus.busy});
        end
      end else if (c == 22) begin
        if ({bus.swap_n, bus.done} !== 2'b01) begin
          miscompares++;
          $display("FAIL toggle_swap: got {swap_n,done}=%b want 01", {bus.swap_n, bus.done});
        end
      end else begin
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL toggle_idle: got busy=%b want 0", bus.busy);
        end
      end
      cycle();
    end
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    $display("txn a_toggle: a_valid 1,0,1,0 in compute, two fires, swap at pass cycle 22");
  endtask

  task automatic test_start_ignored();
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b1;
    start_pass(5'd0, 5'd3, 8'h10);
    for (int c = 1; c <= 24; c++) begin
      if (c == 17) begin
        bus.start_valid = 1'b1;
        bus.cfg_w_rows = 5'd5;
        bus.cfg_a_rows = 5'd0;
        bus.cfg_rbuf_base = 8'h80;
      end else if (c == 19) begin
        bus.start_valid = 1'b0;
      end
      @(negedge clock);
      if (c >= 17 && c <= 20) begin
        vectors++;
        if ({bus.start_ready, bus.mac_r_en_n, bus.rbuf_w_addr} !== {1'b0, 1'b0, 8'(16 + c - 17)}) begin
          miscompares++;
          $display("FAIL ignore_start c=%0d: got srdy=%b ren_n=%b rbuf=%h want 0/0/%h", c,
                   bus.start_ready, bus.mac_r_en_n, bus.rbuf_w_addr, 8'(16 + c - 17));
        end
      end else if (c == 23) begin
        vectors++;
        if ({bus.swap_n, bus.done} !== 2'b01) begin
          miscompares++;
          $display("FAIL ignore_swap: got {swap_n,done}=%b want 01", {bus.swap_n, bus.done});
        end
      end else if (c == 24) begin
        vectors++;
        if (bus.busy !== 1'b0) begin
          miscompares++;
          $display("FAIL ignore_idle: got busy=%b want 0", bus.busy);
        end
      end
      cycle();
    end
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    bus.cfg_w_rows = '0;
    bus.cfg_a_rows = '0;
    bus.cfg_rbuf_base = '0;
    $display("txn start_ignored: mid-pass start with a_rows=0 base=80 left pass unchanged");
  endtask

  task automatic test_reset_drain();
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b1;
    start_pass(5'd0, 5'd3, 8'h10);
    repeat (20) cycle();
    @(negedge clock);
    vectors++;
    if ({bus.busy, bus.swap_n, bus.a_ready} !== 3'b110) begin
      miscompares++;
      $display("FAIL rstdrain_pre: got {busy,swap_n,ardy}=%b want 110",
               {bus.busy, bus.swap_n, bus.a_ready});
    end
    #1;
    reset_n = 1'b0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.start_ready, bus.swap_n, bus.done, bus.mac_r_en_n} !== 5'b01101) begin
      miscompares++;
      $display("FAIL rstdrain_async: got {busy,srdy,swap_n,done,ren_n}=%b want 01101",
               {bus.busy, bus.start_ready, bus.swap_n, bus.done, bus.mac_r_en_n});
    end
    cycle();
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      vectors++;
      if ({bus.swap_n, bus.done, bus.busy} !== 3'b100) begin
        miscompares++;
        $display("FAIL rstdrain_after c=%0d: got {swap_n,done,busy}=%b want 100", c,
                 {bus.swap_n, bus.done, bus.busy});
      end
      cycle();
    end
    $display("txn reset_drain: reset in drain abandoned pass with no swap");
  endtask

  task automatic test_long_load();
    int k;
    bus.w_valid = 1'b1;
    bus.a_valid = 1'b0;
    start_pass(5'd31, 5'd0, 8'h20);
    for (int c = 1; c <= 512; c++) begin
      @(negedge clock);
      vectors++;
      if ({bus.mac_w_en_n, bus.mac_w_col, bus.mac_w_addr}
          !== {1'b0, 4'((c - 1) / 32), 5'((c - 1) % 32)}) begin
        miscompares++;
        $display("FAIL long_load c=%0d: got en_n=%b col=%0d addr=%0d want 0/%0d/%0d", c,
                 bus.mac_w_en_n, bus.mac_w_col, bus.mac_w_addr, (c - 1) / 32, (c - 1) % 32);
      end
      cycle();
    end
    bus.a_valid = 1'b1;
    @(negedge clock);
    vectors++;
    if ({bus.w_ready, bus.a_ready, bus.mac_w_en_n, bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr}
        !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h20}) begin
      miscompares++;
      $display("FAIL long_compute: got wrdy=%b ardy=%b wen_n=%b ren_n=%b raddr=%0d rbuf=%h want 0/1/1/0/0/20",
               bus.w_ready, bus.a_ready, bus.mac_w_en_n, bus.mac_r_en_n, bus.mac_r_addr, bus.rbuf_w_addr);
    end
    k = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      @(negedge clock);
      k++;
      if (bus.done === 1'b1) break;
    end
    vectors++;
    if (k !== 3 || bus.done !== 1'b1) begin
      miscompares++;
      $display("FAIL long_swap: got done=%b after %0d cycles want done=1 after 3", bus.done, k);
    end
    cycle();
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
    cycle();
    $display("txn long_load: 512 weight beats then 1 read, swap 3 cycles later");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_a_toggle();
    test_start_ignored();
    test_reset_drain();
    test_long_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
